object_trajectory: RTL and testbench

OBJECT_TRAJECTORY -- requirements
Module: object_trajectory

---
 rtl/object_trajectory_if.sv | 31 +++
 rtl/object_trajectory.sv | 126 ++++++++++++
 tb/tb_object_trajectory.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/object_trajectory_if.sv
// Launch/position bundle between a trajectory controller and its client.
// Master drives launch request, start state, tick period and hit; slave returns position and status.
// Widths follow the position and velocity parameters of the attached object_trajectory.
interface object_trajectory_if #(
    parameter int XW = 10,
    parameter int YW = 9,
    parameter int VW = 8
);
    logic                 launch;
    logic [XW-1:0]        launch_x;
    logic [YW-1:0]        launch_y;
    logic signed [VW-1:0] launch_vx;
    logic signed [VW-1:0] launch_vy;
    logic [31:0]          tick_period;
    logic                 hit;
    logic [XW-1:0]        posx;
    logic [YW-1:0]        posy;
    logic                 active;
    logic                 ready;
    logic                 exited;

    modport master (
        output launch, launch_x, launch_y, launch_vx, launch_vy, tick_period, hit,
        input  posx, posy, active, ready, exited
    );

    modport slave (
        input  launch, launch_x, launch_y, launch_vx, launch_vy, tick_period, hit,
        output posx, posy, active, ready, exited
    );
endinterface

// File: rtl/object_trajectory.sv
// Ballistic object motion: position integrates velocity once per tick, gravity adds to vy every GRAV_DIV ticks.
// Latency: launch accepted in one edge; first move P edges later, then every P edges (P = max(tick_period,1)).
// Backpressure: ready low while in flight; launches seen then are dropped, hit aborts the flight.
// Ports: clk, rst (sync, active-high), bus (slave): launch/launch_x/launch_y/launch_vx/launch_vy/
//        tick_period/hit in; posx/posy/active/ready/exited out.
module object_trajectory #(
    parameter int XW        = 10,
    parameter int YW        = 9,
    parameter int VW        = 8,
    parameter int X_MAX     = 639,
    parameter int Y_MAX     = 479,
    parameter int GRAV_DIV  = 4,
    parameter int GRAV_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    object_trajectory_if.slave bus
);
    // Next-position arithmetic is wide enough that no sum can wrap, so off-screen
    // in either direction is seen as a plain signed comparison.
    localparam int NW0 = ((XW > YW) ? XW : YW) + 2;
    localparam int NW  = (NW0 > VW) ? NW0 : VW + 1;

    localparam logic signed [NW-1:0] X_LIM = NW'(X_MAX);
    localparam logic signed [NW-1:0] Y_LIM = NW'(Y_MAX);
    localparam logic signed [31:0]   V_POS = 32'((2 ** (VW - 1)) - 1);
    localparam logic signed [31:0]   V_NEG = -32'(2 ** (VW - 1));

    typedef enum logic {IDLE, FLY} state_t;

    state_t               state;
    logic [XW-1:0]        posx;
    logic [YW-1:0]        posy;
    logic signed [VW-1:0] vx;
    logic signed [VW-1:0] vy;
    logic [31:0]          tickCnt;
    logic [31:0]          gravCnt;
    logic                 exited;

    logic [31:0]          period;
    logic                 tick;
    logic signed [NW-1:0] nx;
    logic signed [NW-1:0] ny;
    logic                 offScreen;
    logic                 gravWrap;
    logic signed [31:0]   vyWide;
    logic signed [VW-1:0] vyNext;

    always_comb begin
        period = (bus.tick_period == 32'd0) ? 32'd1 : bus.tick_period;
        // ">=" so a period shortened below the running count ticks on the next edge.
        tick   = (tickCnt >= period - 32'd1);

        nx = NW'(posx) + NW'(vx);
        ny = NW'(posy) + NW'(vy);
        offScreen = (nx < 0) || (nx > X_LIM) || (ny > Y_LIM);

        gravWrap = (gravCnt >= 32'(GRAV_DIV - 1));
        vyWide   = 32'(vy) + 32'(GRAV_STEP);
        if (vyWide > V_POS)
            vyNext = VW'(V_POS);
        else if (vyWide < V_NEG)
            vyNext = VW'(V_NEG);
        else
            vyNext = vyWide[VW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            posx    <= '0;
            posy    <= '0;
            vx      <= '0;
            vy      <= '0;
            tickCnt <= '0;
            gravCnt <= '0;
            exited  <= 1'b0;
        end else begin
            exited <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.launch) begin
                        posx    <= bus.launch_x;
                        posy    <= bus.launch_y;
                        vx      <= bus.launch_vx;
                        vy      <= bus.launch_vy;
                        tickCnt <= '0;
                        gravCnt <= '0;
                        state   <= FLY;
                    end
                end
                FLY: begin
                    if (bus.hit) begin
                        // Slice wins over a same-cycle tick: freeze where we are.
                        state <= IDLE;
                    end else if (tick) begin
                        tickCnt <= '0;
                        if (gravWrap) begin
                            gravCnt <= '0;
                            vy      <= vyNext;
                        end else begin
                            gravCnt <= gravCnt + 32'd1;
                        end
                        if (offScreen) begin
                            exited <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            posx <= nx[XW-1:0];
                            // Ceiling clamp: an upward move past the top pins to row 0.
                            posy <= (ny < 0) ? '0 : ny[YW-1:0];
                        end
                    end else begin
                        tickCnt <= tickCnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.posx   = posx;
    assign bus.posy   = posy;
    assign bus.active = (state == FLY);
    assign bus.ready  = (state == IDLE);
    assign bus.exited = exited;
endmodule

// File: tb/tb_object_trajectory.sv
// Bench for object_trajectory: directed scenarios plus randomized traffic scored against a reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: launches issued while in flight are expected to be dropped.
module tb_object_trajectory;
    localparam int GD = 4;
    localparam int GS = 1;
    localparam int XM = 639;
    localparam int YM = 479;
    localparam int VMAXP = 127;

    logic clk = 1'b0;
    logic rst;
    int   nChecks = 0;
    int   nFail   = 0;

    always #5 clk = ~clk;

    object_trajectory_if #(.XW(10), .YW(9), .VW(8))  bus  ();
    object_trajectory_if #(.XW(10), .YW(12), .VW(8)) bus2 ();

    object_trajectory dut (.clk(clk), .rst(rst), .bus(bus));
    object_trajectory #(.YW(12), .Y_MAX(4000), .GRAV_DIV(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // Reference model: position/velocity as plain integers, one step per clock edge.
    typedef struct packed {
        int x; int y; int vx; int vy; int since; int ticks; bit fly; bit ex;
    } mdl_t;
    mdl_t m = '0;

    function automatic mdl_t step(mdl_t c, bit r, bit l, bit h, int tp, int lx, int ly, int lvx, int lvy);
        mdl_t n = c;
        int p, nx, ny;
        n.ex = 1'b0;
        if (r) begin
            n = '0;
        end else if (!c.fly) begin
            if (l) begin
                n.x = lx; n.y = ly; n.vx = lvx; n.vy = lvy;
                n.since = 0; n.ticks = 0; n.fly = 1'b1;
            end
        end else if (h) begin
            n.fly = 1'b0;
        end else begin
            p = (tp <= 0) ? 1 : tp;
            if (c.since + 1 >= p) begin
                n.since = 0;
                n.ticks = c.ticks + 1;
                nx = c.x + c.vx;
                ny = c.y + c.vy;
                if (n.ticks % GD == 0)
                    n.vy = (c.vy + GS > VMAXP) ? VMAXP : c.vy + GS;
                if (nx < 0 || nx > XM || ny > YM) begin
                    n.ex = 1'b1; n.fly = 1'b0;
                end else begin
                    n.x = nx; n.y = (ny < 0) ? 0 : ny;
                end
            end else begin
                n.since = c.since + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk)
        m <= step(m, rst, bus.launch, bus.hit, int'(bus.tick_period), int'(bus.launch_x),
                  int'(bus.launch_y), int'(bus.launch_vx), int'(bus.launch_vy));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic doLaunch(input int x, input int y, input int vx, input int vy, input int tp);
        bus.launch_x = 10'(x); bus.launch_y = 9'(y);
        bus.launch_vx = 8'(vx); bus.launch_vy = 8'(vy);
        bus.tick_period = 32'(tp);
        bus.launch = 1'b1;
        cyc();
        bus.launch = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.launch = 1'b1; bus.hit = 1'b1;
        repeat (3) cyc();
        nChecks++;
        if ({bus.posx, bus.posy, bus.active, bus.ready, bus.exited} !== {10'd0, 9'd0, 1'b0, 1'b1, 1'b0}) begin
            nFail++;
            $display("FAIL reset_outputs: got x=%0d y=%0d act=%b rdy=%b ex=%b want 0 0 0 1 0",
                     bus.posx, bus.posy, bus.active, bus.ready, bus.exited);
        end
        rst = 1'b0; bus.launch = 1'b0; bus.hit = 1'b0;
        cyc();
    endtask

    task automatic test_trajectory();
        int ex[6] = '{100, 102, 104, 106, 108, 110};
        int ey[6] = '{400, 395, 390, 385, 380, 376};
        doLaunch(100, 400, 2, -5, 3);
        for (int k = 1; k <= 15; k++) begin
            cyc();
            nChecks++;
            if (int'(bus.posx) !== ex[k/3] || int'(bus.posy) !== ey[k/3] || bus.active !== 1'b1) begin
                nFail++;
                $display("FAIL traj_edge%0d: got (%0d,%0d) act=%b want (%0d,%0d) act=1",
                         k, bus.posx, bus.posy, bus.active, ex[k/3], ey[k/3]);
            end
        end
        bus.hit = 1'b1; cyc(); bus.hit = 1'b0;
    endtask

    task automatic test_exit_right();
        doLaunch(638, 200, 3, 0, 1);
        cyc();
        nChecks++;
        if (bus.exited !== 1'b1 || bus.posx !== 10'd638 || bus.posy !== 9'd200 || bus.active !== 1'b0) begin
            nFail++;
            $display("FAIL exit_right_pulse: got ex=%b (%0d,%0d) act=%b want ex=1 (638,200) act=0",
                     bus.exited, bus.posx, bus.posy, bus.active);
        end
        cyc();
        nChecks++;
        if (bus.exited !== 1'b0 || bus.ready !== 1'b1) begin
            nFail++;
            $display("FAIL exit_right_after: got ex=%b rdy=%b want ex=0 rdy=1", bus.exited, bus.ready);
        end
    endtask

    task automatic test_ceiling();
        bit seen = 1'b0;
        int lastY = 0;
        doLaunch(50, 2, 0, -5, 1);
        cyc();
        nChecks++;
        if (bus.posy !== 9'd0 || bus.active !== 1'b1) begin
            nFail++;
            $display("FAIL ceiling_clamp: got y=%0d act=%b want y=0 act=1", bus.posy, bus.active);
        end
        for (int c = 0; c < 2000 && !seen; c++) begin
            lastY = int'(bus.posy);
            cyc();
            if (bus.exited === 1'b1) seen = 1'b1;
        end
        nChecks++;
        if (!seen) begin
            nFail++;
            $display("FAIL ceiling_exit_timeout: got no exit in 2000 cycles want exit via bottom");
        end
        nChecks++;
        if (int'(bus.posy) <= 400 || bus.posx !== 10'd50 || int'(bus.posy) !== lastY) begin
            nFail++;
            $display("FAIL ceiling_exit_pos: got (%0d,%0d) want x=50, y>400 held at %0d",
                     bus.posx, bus.posy, lastY);
        end
    endtask

    task automatic test_hit_on_tick();
        doLaunch(300, 300, 1, 1, 2);
        cyc();
        bus.hit = 1'b1;
        cyc();
        bus.hit = 1'b0;
        nChecks++;
        if (bus.active !== 1'b0 || bus.posx !== 10'd300 || bus.posy !== 9'd300 || bus.exited !== 1'b0) begin
            nFail++;
            $display("FAIL hit_on_tick: got act=%b (%0d,%0d) ex=%b want act=0 (300,300) ex=0",
                     bus.active, bus.posx, bus.posy, bus.exited);
        end
        cyc();
        nChecks++;
        if (bus.exited !== 1'b0 || bus.ready !== 1'b1) begin
            nFail++;
            $display("FAIL hit_no_exit: got ex=%b rdy=%b want ex=0 rdy=1", bus.exited, bus.ready);
        end
        bus.hit = 1'b1; cyc(); bus.hit = 1'b0;
        nChecks++;
        if (bus.ready !== 1'b1 || bus.posx !== 10'd300 || bus.posy !== 9'd300) begin
            nFail++;
            $display("FAIL hit_in_idle: got rdy=%b (%0d,%0d) want rdy=1 (300,300)", bus.ready, bus.posx, bus.posy);
        end
    endtask

    task automatic test_launch_ignored();
        doLaunch(200, 200, 0, 0, 1000);
        repeat (2) cyc();
        bus.launch_x = 10'd10; bus.launch_y = 9'd10; bus.launch_vx = 8'sd5; bus.launch_vy = 8'sd5;
        bus.launch = 1'b1;
        cyc();
        bus.launch = 1'b0;
        repeat (3) cyc();
        nChecks++;
        if (bus.active !== 1'b1 || bus.posx !== 10'd200 || bus.posy !== 9'd200) begin
            nFail++;
            $display("FAIL launch_in_fly: got act=%b (%0d,%0d) want act=1 (200,200)", bus.active, bus.posx, bus.posy);
        end
        rst = 1'b1; bus.launch = 1'b1;
        cyc();
        rst = 1'b0; bus.launch = 1'b0;
        nChecks++;
        if ({bus.posx, bus.posy, bus.active, bus.ready, bus.exited} !== {10'd0, 9'd0, 1'b0, 1'b1, 1'b0}) begin
            nFail++;
            $display("FAIL rst_with_launch: got x=%0d y=%0d act=%b rdy=%b ex=%b want 0 0 0 1 0",
                     bus.posx, bus.posy, bus.active, bus.ready, bus.exited);
        end
        cyc();
        nChecks++;
        if (bus.active !== 1'b0) begin
            nFail++;
            $display("FAIL rst_launch_dropped: got act=%b want 0", bus.active);
        end
    endtask

    task automatic test_saturation();
        bus2.launch_x = 10'd10; bus2.launch_y = 12'd0; bus2.launch_vx = 8'sd0; bus2.launch_vy = 8'sd126;
        bus2.tick_period = 32'd1; bus2.launch = 1'b1;
        cyc();
        bus2.launch = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            nChecks++;
            if (int'(bus2.posy) !== 126 + 127 * (k - 1)) begin
                nFail++;
                $display("FAIL vy_saturate_tick%0d: got y=%0d want y=%0d", k, bus2.posy, 126 + 127 * (k - 1));
            end
        end
        bus2.hit = 1'b1; cyc(); bus2.hit = 1'b0;
    endtask

    task automatic test_random();
        bus.tick_period = 32'd2;
        for (int c = 0; c < 3000; c++) begin
            bus.launch    = ($urandom_range(0, 3) == 0);
            bus.launch_x  = 10'($urandom_range(0, XM));
            bus.launch_y  = 9'($urandom_range(0, YM));
            bus.launch_vx = 8'(int'($urandom_range(0, 24)) - 12);
            bus.launch_vy = 8'(int'($urandom_range(0, 24)) - 12);
            bus.hit       = ($urandom_range(0, 59) == 0);
            rst           = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 99) == 0) bus.tick_period = 32'($urandom_range(0, 4));
            cyc();
            nChecks++;
            if (int'(bus.posx) !== m.x || int'(bus.posy) !== m.y) begin
                nFail++;
                $display("FAIL rand_pos c%0d: got (%0d,%0d) want (%0d,%0d)", c, bus.posx, bus.posy, m.x, m.y);
            end
            nChecks++;
            if (bus.active !== m.fly || bus.ready !== !m.fly || bus.exited !== m.ex) begin
                nFail++;
                $display("FAIL rand_status c%0d: got act=%b rdy=%b ex=%b want act=%b rdy=%b ex=%b",
                         c, bus.active, bus.ready, bus.exited, m.fly, !m.fly, m.ex);
            end
        end
        rst = 1'b0; bus.launch = 1'b0; bus.hit = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.launch = 1'b0; bus.launch_x = '0; bus.launch_y = '0; bus.launch_vx = '0; bus.launch_vy = '0;
        bus.tick_period = 32'd1; bus.hit = 1'b0;
        bus2.launch = 1'b0; bus2.launch_x = '0; bus2.launch_y = '0; bus2.launch_vx = '0; bus2.launch_vy = '0;
        bus2.tick_period = 32'd1; bus2.hit = 1'b0;
        test_reset();
        test_trajectory();
        test_exit_right();
        test_ceiling();
        test_hit_on_tick();
        test_launch_ignored();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
